// File: rtl/multicore_pkg.sv
// Shared types for the core pipeline: data width, load/store op encodings and
// the memory-access stage state enum.
package multicore_pkg;

  localparam int DATA_SIZE = 32;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } t_ldop;

  typedef enum logic [1:0] {
    SB = 2'd0,
    SH = 2'd1,
    SW = 2'd2
  } t_sop;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } t_mem_state;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed byte/half out of the cache word and sign- or
// zero-extends it according to the load op.
module load_align
  import multicore_pkg::*;
(
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic [1:0]           i_addr_lo,
  input  t_ldop                i_ldop,
  output logic [DATA_SIZE-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_addr_lo)
      2'd0:    byte_sel = i_data[7:0];
      2'd1:    byte_sel = i_data[15:8];
      2'd2:    byte_sel = i_data[23:16];
      default: byte_sel = i_data[31:24];
    endcase
    half_sel = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];

    case (i_ldop)
      LB:      o_data = {{(DATA_SIZE-8){byte_sel[7]}}, byte_sel};
      LBU:     o_data = {{(DATA_SIZE-8){1'b0}}, byte_sel};
      LH:      o_data = {{(DATA_SIZE-16){half_sel[15]}}, half_sel};
      LHU:     o_data = {{(DATA_SIZE-16){1'b0}}, half_sel};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time to the data
// cache and presents a registered writeback result with valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no instruction held, ready for a new one
// ST_REQ  | cache request asserted, waiting for i_req_ready
// ST_WAIT | request accepted, waiting for i_data_valid
// ST_RESP | writeback result presented, waiting for i_wb_ready
module mem_access_stage
  import multicore_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int REG_BITS  = 5
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_is_load,
  input  logic                 i_is_store,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_store_data,
  input  t_sop                 i_sop,
  input  t_ldop                i_ldop,
  input  logic [REG_BITS-1:0]  i_rd,
  input  logic                 i_rd_we,
  output logic                 o_req,
  output logic                 o_req_write,
  input  logic                 i_req_ready,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [DATA_SIZE-1:0] o_store_data,
  output t_sop                 o_sop,
  output t_ldop                o_ldop,
  input  logic                 i_data_valid,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_wb_valid,
  input  logic                 i_wb_ready,
  output logic                 o_wb_we,
  output logic [REG_BITS-1:0]  o_wb_rd,
  output logic [DATA_SIZE-1:0] o_wb_data,
  output logic                 o_misaligned
);

  t_mem_state state, state_next;
  logic accept, is_mem, misaligned, rd_we_q;
  logic [DATA_SIZE-1:0] load_word;

  // A store wins when both load and store flags are set.
  function automatic logic is_misaligned(input logic is_store, input t_sop sop,
                                         input t_ldop ldop, input logic [1:0] lo);
    if (is_store) begin
      case (sop)
        SH:      return lo[0];
        SW:      return |lo;
        default: return 1'b0;
      endcase
    end else begin
      case (ldop)
        LH, LHU: return lo[0];
        LW:      return |lo;
        default: return 1'b0;
      endcase
    end
  endfunction

  // Gated by reset so every output reads 0 while reset is held.
  assign o_ready    = i_areset_n & ((state == ST_IDLE) | ((state == ST_RESP) & i_wb_ready));
  assign accept     = i_valid & o_ready;
  assign is_mem     = i_is_load | i_is_store;
  assign misaligned = is_misaligned(i_is_store, i_sop, i_ldop, i_addr[1:0]);

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) state <= ST_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_REQ:  if (i_req_ready)  state_next = ST_WAIT;
      ST_WAIT: if (i_data_valid) state_next = ST_RESP;
      ST_RESP: if (i_wb_ready)   state_next = ST_IDLE;
      default: state_next = state;
    endcase
    if (accept) state_next = (is_mem && !misaligned) ? ST_REQ : ST_RESP;
  end

  load_align u_load_align (
    .i_data   (i_data),
    .i_addr_lo(o_addr[1:0]),
    .i_ldop   (o_ldop),
    .o_data   (load_word)
  );

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_req        <= 1'b0;
      o_req_write  <= 1'b0;
      o_addr       <= '0;
      o_store_data <= '0;
      o_sop        <= SB;
      o_ldop       <= LB;
      rd_we_q      <= 1'b0;
      o_wb_valid   <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_rd      <= '0;
      o_wb_data    <= '0;
      o_misaligned <= 1'b0;
    end else if (accept) begin
      o_req_write  <= i_is_store;
      o_addr       <= i_addr;
      o_store_data <= i_store_data;
      o_sop        <= i_sop;
      o_ldop       <= i_ldop;
      rd_we_q      <= i_rd_we;
      o_wb_rd      <= i_rd;
      o_wb_data    <= DATA_SIZE'(i_addr);
      if (!is_mem) begin
        o_req        <= 1'b0;
        o_wb_valid   <= 1'b1;
        o_wb_we      <= i_rd_we;
        o_misaligned <= 1'b0;
      end else if (misaligned) begin
        o_req        <= 1'b0;
        o_wb_valid   <= 1'b1;
        o_wb_we      <= 1'b0;
        o_misaligned <= 1'b1;
      end else begin
        o_req        <= 1'b1;
        o_wb_valid   <= 1'b0;
        o_wb_we      <= 1'b0;
        o_misaligned <= 1'b0;
      end
    end else begin
      case (state)
        ST_REQ: if (i_req_ready) o_req <= 1'b0;
        ST_WAIT: if (i_data_valid) begin
          o_wb_valid <= 1'b1;
          o_wb_we    <= rd_we_q & ~o_req_write;
          if (!o_req_write) o_wb_data <= load_word;
        end
        ST_RESP: if (i_wb_ready) begin
          o_wb_valid   <= 1'b0;
          o_wb_we      <= 1'b0;
          o_misaligned <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases from the stage's contract plus
// randomized traffic checked each cycle against a transaction-level model.
module tb_mem_access_stage;
  import multicore_pkg::*;

  logic        i_aclk = 1'b0;
  logic        i_areset_n;
  logic        i_valid, o_ready, i_is_load, i_is_store;
  logic [31:0] i_addr, i_store_data;
  t_sop        i_sop;
  t_ldop       i_ldop;
  logic [4:0]  i_rd;
  logic        i_rd_we;
  logic        o_req, o_req_write, i_req_ready;
  logic [31:0] o_addr, o_store_data;
  t_sop        o_sop;
  t_ldop       o_ldop;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        o_wb_valid, i_wb_ready, o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_misaligned;

  mem_access_stage dut (
    .i_aclk(i_aclk), .i_areset_n(i_areset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_sop(i_sop), .i_ldop(i_ldop), .i_rd(i_rd),
    .i_rd_we(i_rd_we), .o_req(o_req), .o_req_write(o_req_write),
    .i_req_ready(i_req_ready), .o_addr(o_addr), .o_store_data(o_store_data),
    .o_sop(o_sop), .o_ldop(o_ldop), .i_data_valid(i_data_valid), .i_data(i_data),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_we(o_wb_we),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
  );

  always #5 i_aclk = ~i_aclk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: which phase the held instruction is in, plus the
  // expected result once it is presented.
  logic        m_busy, m_need_req, m_await, m_present;
  logic        m_is_store;
  logic [31:0] m_addr, m_sdata;
  t_sop        m_sop;
  t_ldop       m_ldop;
  logic [4:0]  m_rd;
  logic        m_rd_we;
  logic        exp_we, exp_mis, exp_chk_data;
  logic [31:0] exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int access_bytes(input logic st, input t_sop so, input t_ldop lo);
    if (st) return 1 << int'(so);
    if (lo == LH || lo == LHU) return 2;
    if (lo == LW) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] d, input logic [31:0] a,
                                            input t_ldop op);
    logic [31:0] w;
    w = d >> (8 * (a % 4));
    case (op)
      LB:      return {{24{w[7]}}, w[7:0]};
      LBU:     return {24'h0, w[7:0]};
      LH:      return {{16{w[15]}}, w[15:0]};
      LHU:     return {16'h0, w[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic exp_ready();
    return i_areset_n & (!m_busy | (m_present & i_wb_ready));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_need_req = 0; m_await = 0; m_present = 0;
    exp_we = 0; exp_mis = 0; exp_chk_data = 0; exp_data = 0;
  endtask

  task automatic model_update();
    logic acc;
    acc = i_valid & exp_ready();
    if (m_present && i_wb_ready) begin
      m_present = 0; m_busy = 0;
    end else if (m_await && i_data_valid) begin
      m_await = 0; m_present = 1; exp_mis = 0;
      if (m_is_store) begin
        exp_we = 0; exp_chk_data = 0;
      end else begin
        exp_we = m_rd_we; exp_chk_data = 1;
        exp_data = m_extract(i_data, m_addr, m_ldop);
      end
    end else if (m_need_req && i_req_ready) begin
      m_need_req = 0; m_await = 1;
    end
    if (acc) begin
      m_busy = 1; m_is_store = i_is_store; m_addr = i_addr; m_sdata = i_store_data;
      m_sop = i_sop; m_ldop = i_ldop; m_rd = i_rd; m_rd_we = i_rd_we;
      if (!(i_is_load || i_is_store)) begin
        m_present = 1; exp_we = i_rd_we; exp_mis = 0; exp_data = i_addr; exp_chk_data = 1;
      end else if ((i_addr % access_bytes(i_is_store, i_sop, i_ldop)) != 0) begin
        m_present = 1; exp_we = 0; exp_mis = 1; exp_data = i_addr; exp_chk_data = 1;
      end else begin
        m_need_req = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("o_req", 32'(o_req), 32'(m_need_req));
    if (m_need_req) begin
      chk("o_addr", o_addr, m_addr);
      chk("o_req_write", 32'(o_req_write), 32'(m_is_store));
      chk("o_store_data", o_store_data, m_sdata);
      if (m_is_store) chk("o_sop", 32'(o_sop), 32'(m_sop));
      else            chk("o_ldop", 32'(o_ldop), 32'(m_ldop));
    end
    chk("o_wb_valid", 32'(o_wb_valid), 32'(m_present));
    if (m_present) begin
      chk("o_wb_we", 32'(o_wb_we), 32'(exp_we));
      chk("o_wb_rd", 32'(o_wb_rd), 32'(m_rd));
      chk("o_misaligned", 32'(o_misaligned), 32'(exp_mis));
      if (exp_chk_data) chk("o_wb_data", o_wb_data, exp_data);
    end
  endtask

  task automatic step(input logic v, input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] sd, input t_sop so, input t_ldop lo,
                      input logic [4:0] rd, input logic we, input logic rr,
                      input logic dv, input logic [31:0] d, input logic wr);
    @(negedge i_aclk);
    compare_outputs();
    i_valid = v; i_is_load = ld; i_is_store = st; i_addr = a; i_store_data = sd;
    i_sop = so; i_ldop = lo; i_rd = rd; i_rd_we = we; i_req_ready = rr;
    i_data_valid = dv; i_data = d; i_wb_ready = wr;
    #1;
    chk("o_ready", 32'(o_ready), 32'(exp_ready()));
    @(posedge i_aclk);
    model_update();
  endtask

  task automatic idle(input logic rr, input logic dv, input logic [31:0] d, input logic wr);
    step(0, 0, 0, 32'h0, 32'h0, SB, LB, 5'd0, 0, rr, dv, d, wr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(o_req), 0);
    chk({tag, "_req_write"}, 32'(o_req_write), 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_store_data"}, o_store_data, 0);
    chk({tag, "_wb_valid"}, 32'(o_wb_valid), 0);
    chk({tag, "_wb_we"}, 32'(o_wb_we), 0);
    chk({tag, "_wb_rd"}, 32'(o_wb_rd), 0);
    chk({tag, "_wb_data"}, o_wb_data, 0);
    chk({tag, "_misaligned"}, 32'(o_misaligned), 0);
    chk({tag, "_ready"}, 32'(o_ready), 0);
  endtask

  initial begin
    i_areset_n = 0; i_valid = 0; i_is_load = 0; i_is_store = 0; i_addr = 0;
    i_store_data = 0; i_sop = SB; i_ldop = LB; i_rd = 0; i_rd_we = 0;
    i_req_ready = 0; i_data_valid = 0; i_data = 0; i_wb_ready = 0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge i_aclk);
    @(negedge i_aclk) i_areset_n = 1;

    // Non-memory op, then back-to-back with writeback stall.
    step(1, 0, 0, 32'h1234, 32'h0, SB, LB, 5'd5, 1, 0, 0, 32'h0, 0);
    #1;
    chk("alu_wb_valid", 32'(o_wb_valid), 1);
    chk("alu_wb_data", o_wb_data, 32'h1234);
    chk("alu_wb_we", 32'(o_wb_we), 1);
    chk("alu_no_req", 32'(o_req), 0);
    step(1, 0, 0, 32'h55, 32'h0, SB, LB, 5'd6, 1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h55, 32'h0, SB, LB, 5'd6, 1, 0, 0, 32'h0, 0);
    #1;
    chk("stall_wb_data_held", o_wb_data, 32'h1234);
    chk("stall_ready_low", 32'(o_ready), 0);
    step(1, 0, 0, 32'h55, 32'h0, SB, LB, 5'd6, 1, 0, 0, 32'h0, 1);
    #1;
    chk("b2b_wb_data", o_wb_data, 32'h55);
    chk("b2b_wb_rd", 32'(o_wb_rd), 6);
    idle(0, 0, 32'h0, 1);

    // LB sign-extend, minimum latency.
    step(1, 1, 0, 32'h1003, 32'h0, SB, LB, 5'd7, 1, 1, 0, 32'h0, 1);
    idle(1, 0, 32'h0, 1);
    idle(1, 1, 32'h80FF_0011, 1);
    #1;
    chk("lb_model", exp_data, 32'hFFFF_FF80);
    chk("lb_wb_data", o_wb_data, 32'hFFFF_FF80);
    idle(0, 0, 32'h0, 1);

    // LHU zero-extend.
    step(1, 1, 0, 32'h1002, 32'h0, SB, LHU, 5'd8, 1, 1, 0, 32'h0, 1);
    idle(1, 0, 32'h0, 1);
    idle(1, 1, 32'h80FF_0011, 1);
    #1;
    chk("lhu_model", exp_data, 32'h0000_80FF);
    chk("lhu_wb_data", o_wb_data, 32'h0000_80FF);
    idle(0, 0, 32'h0, 1);

    // Store held under request backpressure.
    step(1, 0, 1, 32'h2000, 32'hDEAD_BEEF, SW, LB, 5'd9, 1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(0, 0, 32'h0, 1);
      #1;
      chk("sw_req_held", 32'(o_req), 1);
      chk("sw_addr_held", o_addr, 32'h2000);
      chk("sw_data_held", o_store_data, 32'hDEAD_BEEF);
    end
    idle(1, 0, 32'h0, 0);
    idle(0, 1, 32'h0, 0);
    #1;
    chk("sw_wb_valid", 32'(o_wb_valid), 1);
    chk("sw_wb_we", 32'(o_wb_we), 0);
    idle(0, 0, 32'h0, 1);

    // Misaligned LW.
    step(1, 1, 0, 32'h1001, 32'h0, SB, LW, 5'd10, 1, 1, 0, 32'h0, 0);
    #1;
    chk("mis_flag", 32'(o_misaligned), 1);
    chk("mis_no_req", 32'(o_req), 0);
    chk("mis_wb_we", 32'(o_wb_we), 0);
    idle(0, 0, 32'h0, 1);

    // Reset while waiting for the cache; a late data_valid must be ignored.
    step(1, 1, 0, 32'h3000, 32'h0, SB, LW, 5'd11, 1, 1, 0, 32'h0, 1);
    idle(1, 0, 32'h0, 1);
    #2;
    i_areset_n = 0;
    #1;
    chk_all_zero("wait_reset");
    model_reset();
    @(posedge i_aclk);
    @(negedge i_aclk) i_areset_n = 1;
    idle(0, 1, 32'hFFFF_FFFF, 1);
    idle(0, 0, 32'h0, 1);
    #1;
    chk("post_reset_no_wb", 32'(o_wb_valid), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic ld, st;
      ld = $urandom_range(0, 2) != 0;
      st = $urandom_range(0, 2) == 0;
      step($urandom_range(0, 1) == 1, ld, st, $urandom & 32'h0000_FFFF, $urandom,
           t_sop'($urandom_range(0, 2)), t_ldop'($urandom_range(0, 4)),
           5'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 7);
    end
    @(negedge i_aclk);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory-access stage between execute and `data_cache`. Accepts one instruction at a time from execute and issues loads and stores to the data cache via the `o_req`/`i_req_ready` handshake. Waits for cache completion, then extracts, aligns and sign/zero-extends load data. Presents a single registered writeback result to the writeback stage with valid/ready flow control.

## Interface
Parameters:
- `ADDR_SIZE`, 32, address width
- `REG_BITS`, 5, destination register index width

Ports (`DATA_SIZE` comes from `multicore_pkg`):
- `i_aclk` in 1: system clock
- `i_areset_n` in 1: asynchronous, active-low reset
- `i_valid` in 1: execute presents an instruction
- `o_ready` out 1: stage accepts the instruction this cycle
- `i_is_load` in 1: instruction is a load
- `i_is_store` in 1: instruction is a store
- `i_addr` in ADDR_SIZE: effective address, or ALU result for non-memory ops
- `i_store_data` in DATA_SIZE: rs2 value
- `i_sop` in t_sop: store size
- `i_ldop` in t_ldop: load size and sign
- `i_rd` in REG_BITS: destination register
- `i_rd_we` in 1: instruction writes rd
- `o_req` out 1: cache request
- `o_req_write` out 1: request is a store
- `i_req_ready` in 1: cache accepts the request
- `o_addr` out ADDR_SIZE: cache address
- `o_store_data` out DATA_SIZE: unshifted rs2; the cache performs byte-lane placement
- `o_sop` out t_sop: store size to the cache
- `o_ldop` out t_ldop: load op to the cache
- `i_data_valid` in 1: cache completed the access
- `i_data` in DATA_SIZE: aligned word containing `o_addr`
- `o_wb_valid` out 1: writeback result valid
- `i_wb_ready` in 1: writeback consumes the result
- `o_wb_we` out 1: write rd
- `o_wb_rd` out REG_BITS: destination register
- `o_wb_data` out DATA_SIZE: result
- `o_misaligned` out 1: access was misaligned; no cache request was issued

## Operation
The stage is a four-state FSM: IDLE, REQ, WAIT, RESP.

- **Ready:** `o_ready = (IDLE) | (RESP & i_wb_ready)`. Acceptance is `i_valid & o_ready`. On acceptance, all inputs are captured into registers.
- **Accepted non-memory op:** go to RESP with `o_wb_data = i_addr` and `o_wb_we = i_rd_we`.
- **Accepted misaligned access:** LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`.
  - Go to RESP with `o_misaligned=1`, `o_wb_we=0`, `o_wb_data=addr`.
  - No `o_req` is issued.
- **Accepted aligned load/store:** go to REQ.
- **REQ:**
  - `o_req=1`, `o_req_write=is_store`; address, data and op outputs are held stable.
  - On `i_req_ready`, go to WAIT and drop `o_req` next cycle.
- **WAIT:**
  - On `i_data_valid`, go to RESP.
  - For a load, `o_wb_data` = extracted `i_data`, and `o_wb_we = i_rd_we`.
  - For a store, `o_wb_we = 0`.
- **`i_data_valid` outside WAIT:** ignored.
- **RESP:**
  - `o_wb_valid=1`, and all wb outputs are held until `i_wb_ready`.
  - On `i_wb_ready` with a new acceptance in the same cycle, take the next state per the new instruction (back-to-back operation).
  - On `i_wb_ready` without a new acceptance, go to IDLE.
- **Load extraction,** with `b = addr[1:0]`:
  - LB/LBU select `i_data[8b+7:8b]`.
  - LH/LHU select `i_data[16·addr[1]+15:16·addr[1]]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through.
- **Both `i_is_load` and `i_is_store` set:** the instruction is treated as a store.

## Timing
- **Reset:** asynchronous. All outputs are 0 and the state is IDLE, including during an outstanding cache request. The cache shares the reset, so no cancellation protocol exists.
- **Non-memory op:** accepted in cycle N, `o_wb_valid` in N+1.
- **Request issue:** an op accepted in cycle N asserts `o_req` in N+1.
- **Request handshake:** completes in the first cycle with `o_req & i_req_ready`.
- **Cache response:** `i_data_valid` is sampled no earlier than the cycle after the handshake. `o_wb_valid` rises the cycle after `i_data_valid`.
- **Minimum load-use latency:** 3 cycles from acceptance to `o_wb_valid`, assuming `i_req_ready` is already high and the cache responds the cycle after the handshake.
- **Outputs:** all are registered. `o_ready` is the only combinational output; it depends on the state and `i_wb_ready`.
- **Throughput:** one memory op in flight at most.

## Structure
- `multicore_pkg` holds:
  - `DATA_SIZE`
  - `t_ldop` (LB, LH, LW, LBU, LHU)
  - `t_sop` (SB, SH, SW)
  - the FSM state enum `t_mem_state`
- Sub-module `load_align`: combinational; inputs `i_data`, `addr[1:0]`, `t_ldop`; output the extended word.
- Misalignment check: a local function in this module.

## Test plan
- **Non-memory op:** `i_addr=0x1234`, `rd=5` → `o_wb_valid` next cycle, `o_wb_data=0x1234`, `o_wb_we=1`, `o_req` never asserted.
- **LB sign-extend:** at `0x1003`, `i_data=0x80FF_0011` → `o_wb_data=0xFFFF_FF80`.
- **LHU zero-extend:** at `0x1002`, same data → `o_wb_data=0x0000_80FF`.
- **Store with backpressure:** SW at `0x2000`, data `0xDEADBEEF`, `i_req_ready` low for 3 cycles → `o_req`, `o_addr`, `o_store_data` stable all 4 cycles. After `i_data_valid`: `o_wb_valid=1`, `o_wb_we=0`.
- **Misaligned:** LW at `0x1001` → no `o_req`, `o_misaligned=1` next cycle, `o_wb_we=0`.
- **Back-to-back and reset:**
  - Hold `i_wb_ready=0` for 2 cycles in RESP → wb outputs held, `o_ready=0`.
  - Then raise `i_wb_ready` with a new `i_valid` → next op accepted in that same cycle.
  - Separately, assert `i_areset_n=0` in WAIT → all outputs 0 immediately, and an `i_data_valid` after reset release is ignored.
